// File: rtl/mipi_frame_transmitter.sv
// Frames a DLEN-byte payload into SOF preamble, marker, header, data, trailer and idle gap words.
// All outputs registered; one frame occupies SOF_REPS+3+NW+GAP busy cycles, start ignored while busy.
module mipi_frame_transmitter #(
   parameter int          DLEN     = 6,
   parameter logic [23:0] SOF      = 24'hEAFF99,
   parameter int          SOF_REPS = 2,
   parameter int          GAP      = 20
) (
   input  logic                tx_pixel_clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [DLEN*8-1:0]   payload,
   input  logic [7:0]          dtype,
   input  logic [7:0]          phl_id,
   output logic [47:0]         packet,
   output logic                my_mipi_tx_VALID,
   output logic                busy,
   output logic                done
);

   localparam int          W      = DLEN * 8;
   localparam int          NW     = DLEN / 6;
   localparam logic [7:0]  REPS8  = 8'(SOF_REPS);
   localparam logic [7:0]  NW8    = 8'(NW);
   localparam logic [7:0]  GAP8   = 8'(GAP);
   localparam logic [47:0] SOFSOF = {SOF, SOF};

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PRE   = 3'd1;
   localparam logic [2:0] S_MARK  = 3'd2;
   localparam logic [2:0] S_HDR   = 3'd3;
   localparam logic [2:0] S_DATA  = 3'd4;
   localparam logic [2:0] S_TRAIL = 3'd5;
   localparam logic [2:0] S_GAP   = 3'd6;

   logic [2:0]  state_q, state_d;
   logic [W-1:0] sh_q, sh_d;
   logic [7:0]  dtype_q, dtype_d;
   logic [7:0]  phl_q, phl_d;
   logic [7:0]  rep_q, rep_d;
   logic [7:0]  wcnt_q, wcnt_d;
   logic [7:0]  gap_q, gap_d;
   logic [47:0] pkt_q, pkt_d;
   logic        vld_q, vld_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [47:0] chunk;
   logic [47:0] data_word;
   logic [47:0] hdr_word;

   // The receiver reassembles each 48-bit word with its halves exchanged.
   assign chunk     = sh_q[W-1 -: 48];
   assign data_word = {chunk[23:0], chunk[47:24]};
   assign hdr_word  = {dtype_q, 32'(DLEN), phl_q};

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      dtype_d = dtype_q;
      phl_d   = phl_q;
      rep_d   = rep_q;
      wcnt_d  = wcnt_q;
      gap_d   = gap_q;
      pkt_d   = pkt_q;
      vld_d   = vld_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            pkt_d  = 48'h0;
            vld_d  = 1'b0;
            busy_d = 1'b0;
            if (start) begin
               sh_d    = payload;
               dtype_d = dtype;
               phl_d   = phl_id;
               busy_d  = 1'b1;
               pkt_d   = SOFSOF;
               vld_d   = 1'b1;
               rep_d   = 8'd1;
               state_d = S_PRE;
            end
         end
         S_PRE: begin
            if (rep_q < REPS8) begin
               pkt_d = SOFSOF;
               rep_d = rep_q + 8'd1;
            end else begin
               // The receiver treats the word after the first non-SOF word as the header.
               pkt_d   = 48'h0;
               state_d = S_MARK;
            end
         end
         S_MARK: begin
            pkt_d   = hdr_word;
            state_d = S_HDR;
         end
         S_HDR: begin
            pkt_d   = data_word;
            sh_d    = sh_q << 48;
            wcnt_d  = 8'd1;
            state_d = S_DATA;
         end
         S_DATA: begin
            if (wcnt_q < NW8) begin
               pkt_d  = data_word;
               sh_d   = sh_q << 48;
               wcnt_d = wcnt_q + 8'd1;
            end else begin
               pkt_d   = 48'h0;
               state_d = S_TRAIL;
            end
         end
         S_TRAIL: begin
            pkt_d   = 48'h0;
            vld_d   = 1'b0;
            gap_d   = 8'd1;
            state_d = S_GAP;
         end
         S_GAP: begin
            pkt_d = 48'h0;
            vld_d = 1'b0;
            if (gap_q == GAP8) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         default: begin
            pkt_d   = 48'h0;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         dtype_q <= 8'h0;
         phl_q   <= 8'h0;
         rep_q   <= 8'h0;
         wcnt_q  <= 8'h0;
         gap_q   <= 8'h0;
         pkt_q   <= 48'h0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         dtype_q <= dtype_d;
         phl_q   <= phl_d;
         rep_q   <= rep_d;
         wcnt_q  <= wcnt_d;
         gap_q   <= gap_d;
         pkt_q   <= pkt_d;
         vld_q   <= vld_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign packet           = pkt_q;
   assign my_mipi_tx_VALID = vld_q;
   assign busy             = busy_q;
   assign done             = done_q;

endmodule
